// File: rtl/tdc_channel_cfg_reg.sv
// Holds the host channel-activation word and publishes it to TDC_enable through a notify/request/ack handshake.
// Notify 1 cycle after pending, ack and data 1 cycle after request; host writes are never stalled, only coalesced.
module tdc_channel_cfg_reg #(
  parameter int CHANNEL_COUNT  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr_en,
  input  logic [16:0] cfg_wr_data,
  output logic        cfg_busy,
  output logic        channel_changed,
  input  logic        read_active_channel,
  output logic        read_ack,
  output logic [16:0] activate_channels,
  output logic [7:0]  update_count
);

  localparam logic [15:0] CH_MASK = 16'((17'd1 << CHANNEL_COUNT) - 17'd1);
  localparam int          TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, NOTIFY, ACK} state_t;

  state_t          state;
  logic [16:0]     staging;
  logic [16:0]     wr_norm;
  logic            pending;
  logic [TW-1:0]   tcnt;
  logic            wr_sets_pending;

  // Master switch forces every implemented channel on; unimplemented channels always read 0.
  always_comb begin
    wr_norm        = 17'h0;
    wr_norm[16]    = cfg_wr_data[16];
    wr_norm[15:0]  = (cfg_wr_data[15:0] & CH_MASK) | (cfg_wr_data[16] ? CH_MASK : 16'h0);
  end

  assign wr_sets_pending = cfg_wr_en && ((wr_norm != activate_channels) || (state != IDLE));
  assign cfg_busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      staging           <= 17'h0;
      pending           <= 1'b0;
      tcnt              <= '0;
      channel_changed   <= 1'b0;
      read_ack          <= 1'b0;
      activate_channels <= 17'h0;
      update_count      <= 8'h0;
    end else begin
      channel_changed <= 1'b0;
      read_ack        <= 1'b0;
      if (cfg_wr_en) staging <= wr_norm;

      case (state)
        IDLE: begin
          if (pending) begin
            state           <= NOTIFY;
            channel_changed <= 1'b1;
            tcnt            <= '0;
          end
        end
        NOTIFY: begin
          if (read_active_channel) begin
            // Snapshot takes the staging value from before any same-edge write.
            activate_channels <= staging;
            pending           <= 1'b0;
            read_ack          <= 1'b1;
            update_count      <= update_count + 8'd1;
            state             <= ACK;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tcnt == TMAX) begin
              channel_changed <= 1'b1;
              tcnt            <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        ACK: begin
          if (!read_active_channel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A write on the ack edge wins over the clear, so it triggers a fresh handshake.
      if (wr_sets_pending) pending <= 1'b1;
    end
  end

endmodule
